mc_control_unit: RTL



---
 rtl/mc_control_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: decodes single-cycle ops and sequences MULT/DIV through an iterative unit.
// Latency: single-cycle ops 0 cycles (combinational); MULT/DIV take N+2 cycles (DECODE, N busy, write-back).
// Backpressure: pc_stall holds fetch while a MULT/DIV is in flight; no timeout in handshake mode.
//
// Ports: clk/rst (async active-high); instr_valid/opcode/funct from fetch; md_done from the mul/div unit;
//        RegDst..BranchNE, ALUCtrl to the datapath; md_start to the mul/div unit; pc_stall to fetch;
//        illegal one-cycle flag and saturating illegal_cnt.
module mc_control_unit #(
    parameter int MUL_CYCLES   = 4,
    parameter int DIV_CYCLES   = 16,
    parameter bit MD_HANDSHAKE = 1'b0,
    parameter int ILL_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 md_done,
    output logic                 RegDst,
    output logic                 ALUSrc,
    output logic                 MemToReg,
    output logic                 RegWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 BranchEQ,
    output logic                 BranchNE,
    output logic [3:0]           ALUCtrl,
    output logic                 md_start,
    output logic                 pc_stall,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] illegal_cnt
);
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0101;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    typedef enum logic [1:0] {DECODE, MD_BUSY, MD_WB} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_div_q, op_div_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic                 ill;
    logic [3:0]           md_alu;

    assign md_alu      = op_div_q ? ALU_DIV : ALU_MUL;
    assign illegal_cnt = ill_cnt_q;

    always_comb begin
        RegDst    = 1'b0;
        ALUSrc    = 1'b0;
        MemToReg  = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        BranchEQ  = 1'b0;
        BranchNE  = 1'b0;
        ALUCtrl   = ALU_NOP;
        md_start  = 1'b0;
        pc_stall  = 1'b0;
        ill       = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        ill_cnt_d = ill_cnt_q;

        // Outputs are combinational from opcode/funct, so reset must mask them
        // explicitly to be low for its whole duration, not just after an edge.
        if (!rst) begin
            case (state_q)
                DECODE: begin
                    if (instr_valid) begin
                        case (opcode)
                            OP_R: begin
                                case (funct)
                                    FN_ADD: begin RegDst = 1'b1; RegWrite = 1'b1; ALUCtrl = ALU_ADD; end
                                    FN_SUB: begin RegDst = 1'b1; RegWrite = 1'b1; ALUCtrl = ALU_SUB; end
                                    FN_AND: begin RegDst = 1'b1; RegWrite = 1'b1; ALUCtrl = ALU_AND; end
                                    FN_OR:  begin RegDst = 1'b1; RegWrite = 1'b1; ALUCtrl = ALU_OR;  end
                                    FN_MULT, FN_DIV: begin
                                        // Write-back is deferred to MD_WB; only the start pulse goes out now.
                                        md_start = 1'b1;
                                        pc_stall = 1'b1;
                                        RegDst   = 1'b1;
                                        op_div_d = (funct == FN_DIV);
                                        ALUCtrl  = (funct == FN_DIV) ? ALU_DIV : ALU_MUL;
                                        cnt_d    = (funct == FN_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                                        state_d  = MD_BUSY;
                                    end
                                    default: ill = 1'b1;
                                endcase
                            end
                            OP_LW: begin
                                ALUSrc = 1'b1; MemToReg = 1'b1; RegWrite = 1'b1; MemRead = 1'b1; ALUCtrl = ALU_ADD;
                            end
                            OP_SW:  begin ALUSrc = 1'b1; MemWrite = 1'b1; ALUCtrl = ALU_ADD; end
                            OP_BEQ: begin BranchEQ = 1'b1; ALUCtrl = ALU_SUB; end
                            OP_BNE: begin BranchNE = 1'b1; ALUCtrl = ALU_SUB; end
                            default: ill = 1'b1;
                        endcase
                    end
                    if (ill && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
                        ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
                    end
                end
                MD_BUSY: begin
                    pc_stall = 1'b1;
                    RegDst   = 1'b1;
                    ALUCtrl  = md_alu;
                    if (MD_HANDSHAKE) begin
                        if (md_done) state_d = MD_WB;
                    end else begin
                        // Counter holds the busy cycles still to go including this one.
                        if (cnt_q <= CNT_W'(1)) state_d = MD_WB;
                        else                    cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                MD_WB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    ALUCtrl  = md_alu;
                    state_d  = DECODE;
                end
                default: state_d = DECODE;
            endcase
        end
        illegal = ill;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DECODE;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            ill_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end
endmodule
